pblaze_io_hub: RTL and testbench
================================

Name: pblaze_io_hub

Overview:
Parametrised PicoBlaze (kcpsm6) port-space peripheral hub; the next generation of the single-CPU wrapper's I/O glue.
- Sits between the kcpsm6 port bus (port_id / strobes / in_port / out_port / interrupt) and fabric logic.
- Provides NUM_OUT writable output registers and NUM_IN readable input channels with read-pop strobes.
- Provides a NUM_IRQ-source edge-latched interrupt controller implementing the kcpsm6 interrupt / interrupt_ack handshake.

Parameters:
- NUM_OUT, 4, number of 8-bit output registers (1..16).
- NUM_IN, 4, number of 8-bit input channels (1..16).
- NUM_IRQ, 4, number of interrupt sources (1..8).
- BASE_ADDR, 8'h00, port_id base of the block's 64-port window; low 6 bits must be 0.
- OUT_RESET, 8'h00, reset value of every output register.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- port_id  in  8  kcpsm6 port address.
- write_strobe  in  1  kcpsm6 write strobe.
- out_port  in  8  kcpsm6 write data.
- read_strobe  in  1  kcpsm6 read strobe.
- in_port  out  8  read data to kcpsm6.
- interrupt  out  1  interrupt request to kcpsm6.
- interrupt_ack  in  1  kcpsm6 interrupt acknowledge.
- out_regs  out  8*NUM_OUT  output registers; channel k is bits [8k+7:8k].
- in_data  in  8*NUM_IN  input channel data; same packing as out_regs.
- in_pop  out  NUM_IN  one-cycle pulse: channel k was read by the CPU.
- irq_src  in  NUM_IRQ  interrupt sources, synchronous to clk, level.

Behaviour:
- Reset (reset low, asynchronous):
  - out_regs = OUT_RESET on every channel.
  - in_port = 0, in_pop = 0, interrupt = 0.
  - irq_status = 0, irq_mask = 0.
  - irq_src edge-detect history = 0, irq state = IDLE.
- Address decode: hit when port_id[7:6] == BASE_ADDR[7:6]; offset = port_id[5:0].
- Register map (offset):
  - 0x00..0x0F: OUT[k], read/write; k >= NUM_OUT unmapped.
  - 0x10..0x1F: IN[k], read-only; k >= NUM_IN unmapped.
  - 0x20: IRQ_STATUS, read; write-1-to-clear.
  - 0x21: IRQ_MASK, read/write.
  - 0x22: IRQ_PEND, read-only, = status & mask.
  - 0x23: ID, read-only, = {NUM_IRQ[3:0], 4'h1}.
  - All other offsets read 0x00; writes to them are ignored.
- Writes: on write_strobe & hit, the addressed register updates on the same clock edge. Unused upper bits of STATUS and MASK (>= NUM_IRQ) stay 0.
- Reads:
  - in_port is registered every cycle from the port_id decode; latency is 1 cycle, valid for the kcpsm6 two-cycle port_id window.
  - Unmapped or miss returns 0x00.
  - on read_strobe & hit on IN[k], in_pop[k] pulses high for exactly 1 cycle (the cycle after read_strobe).
  - Reads of other registers have no side effects.
- Interrupt sources:
  - irq_rise = irq_src & ~irq_src_d (1-cycle registered history).
  - A rise sets irq_status[i].
  - A rise and a W1C of the same bit in the same cycle: set wins.
- Interrupt FSM (registered interrupt output):
  - IDLE: if |pend, go to REQ with interrupt=1.
  - REQ: hold interrupt=1 until interrupt_ack; on ack, interrupt=0 and go to HOLDOFF.
  - HOLDOFF: one cycle with interrupt=0, then IDLE. This guarantees a low gap between requests; pend is re-evaluated in IDLE.
  - Mask change or W1C while in REQ does not drop interrupt; the request stays held until ack, as kcpsm6 requires.
  - interrupt_ack received in IDLE or HOLDOFF is ignored.
- Reset asserted mid-transaction: all state clears immediately; no in_pop is emitted on release.

Decomposition:
- Shared package pblaze_io_pkg:
  - register offset constants: OFS_OUT=6'h00, OFS_IN=6'h10, OFS_STAT=6'h20, OFS_MASK=6'h21, OFS_PEND=6'h22, OFS_ID=6'h23;
  - IRQ FSM state encoding (IDLE, REQ, HOLDOFF);
  - ID nibble 4'h1.
- Sub-module pblaze_irq_ctrl: edge detect, status/mask registers, FSM, parametrised by NUM_IRQ. The hub instantiates it and keeps decode, OUT registers, and the read mux.

Test Plan:
- Reset then release; read port BASE+0x00 and BASE+0x23 -> in_port 0x00 and 0x41 (NUM_IRQ=4).
- Write 0xA5 to BASE+0x02 -> out_regs[23:16]=0xA5 the next edge. Write to BASE+0x07 (NUM_OUT=4) -> no out_regs change; read returns 0x00.
- in_data ch1 = 0x3C; read BASE+0x11 with read_strobe -> in_port=0x3C; in_pop=4'b0010 for exactly one cycle. Read BASE+0x21 -> in_pop stays 0.
- mask=0x05; pulse irq_src[2] -> status=0x04, interrupt=1 held; ack after 10 cycles -> interrupt=0 next edge, at least 1 low cycle. W1C 0x04 -> pend 0, no re-request.
- Source 0 rises in the same cycle as a W1C 0x01 -> status bit 0 stays 1; interrupt re-asserts after HOLDOFF.
- Assert reset while interrupt=1 and out_regs are nonzero -> interrupt=0, out_regs=OUT_RESET, status=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/pblaze_io_pkg.sv
// Shared definitions for the kcpsm6 port-space hub: register offsets,
// interrupt FSM encoding and the ID register layout.
package pblaze_io_pkg;

    localparam logic [5:0] OFS_OUT  = 6'h00;
    localparam logic [5:0] OFS_IN   = 6'h10;
    localparam logic [5:0] OFS_STAT = 6'h20;
    localparam logic [5:0] OFS_MASK = 6'h21;
    localparam logic [5:0] OFS_PEND = 6'h22;
    localparam logic [5:0] OFS_ID   = 6'h23;

    localparam logic [3:0] ID_NIBBLE = 4'h1;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_HOLDOFF = 2'd2
    } irq_state_e;

    // The upper nibble of the ID register holds the interrupt source count.
    function automatic logic [7:0] id_byte(input int num_irq);
        logic [31:0] n;
        n = num_irq;
        return {n[3:0], ID_NIBBLE};
    endfunction

endpackage

// File: rtl/pblaze_io_hub_if.sv
// kcpsm6 port bus as seen by a port-space peripheral.
interface pblaze_io_hub_if;
    // Strobe semantics: write_strobe/read_strobe are single-cycle qualifiers of
    // port_id; a write lands on the strobe edge, read data is registered and
    // valid one cycle later. interrupt is a level held until interrupt_ack.
    logic [7:0] port_id;
    logic       write_strobe;
    logic [7:0] out_port;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, write_strobe, out_port, read_strobe, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, write_strobe, out_port, read_strobe, interrupt_ack,
        output in_port, interrupt
    );

endinterface

// File: rtl/pblaze_irq_ctrl.sv
// Edge-latched interrupt controller: rise detect, status/mask registers and
// the request/acknowledge state machine driving the kcpsm6 interrupt line.
module pblaze_irq_ctrl
    import pblaze_io_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               stat_w1c,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] wdata,
    input  logic               ack,
    output logic [NUM_IRQ-1:0] status,
    output logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ-1:0] pend,
    output logic               interrupt,
    output irq_state_e         state
);

    logic [NUM_IRQ-1:0] src_d;
    logic [NUM_IRQ-1:0] rise;

    assign rise = irq_src & ~src_d;
    assign pend = status & mask;

    // A new rise is OR-ed in after the clear so it is never lost to a W1C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_d  <= '0;
            status <= '0;
            mask   <= '0;
        end else begin
            src_d <= irq_src;
            if (stat_w1c) begin
                status <= (status & ~wdata) | rise;
            end else begin
                status <= status | rise;
            end
            if (mask_we) begin
                mask <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IRQ_IDLE;
            interrupt <= 1'b0;
        end else begin
            case (state)
                IRQ_IDLE: begin
                    if (|pend) begin
                        state     <= IRQ_REQ;
                        interrupt <= 1'b1;
                    end
                end
                IRQ_REQ: begin
                    // Held regardless of pend until the CPU acknowledges.
                    if (ack) begin
                        state     <= IRQ_HOLDOFF;
                        interrupt <= 1'b0;
                    end
                end
                IRQ_HOLDOFF: begin
                    state     <= IRQ_IDLE;
                    interrupt <= 1'b0;
                end
                default: begin
                    state     <= IRQ_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pblaze_io_hub.sv
// kcpsm6 port-space hub: address decode, output registers, input channels
// with pop strobes, registered read mux and the interrupt controller.
module pblaze_io_hub
    import pblaze_io_pkg::*;
#(
    parameter int         NUM_OUT   = 4,
    parameter int         NUM_IN    = 4,
    parameter int         NUM_IRQ   = 4,
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter logic [7:0] OUT_RESET = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    pblaze_io_hub_if.slave        bus,
    output logic [8*NUM_OUT-1:0]  out_regs,
    input  logic [8*NUM_IN-1:0]   in_data,
    output logic [NUM_IN-1:0]     in_pop,
    input  logic [NUM_IRQ-1:0]    irq_src,
    output irq_state_e            dbg_irq_state
);

    localparam logic [7:0] ID_VAL = id_byte(NUM_IRQ);

    logic               hit;
    logic [5:0]         ofs;
    logic               we;
    logic [7:0]         out_q [NUM_OUT];
    logic [7:0]         rdata;
    logic [NUM_IN-1:0]  pop_d;
    logic [NUM_IRQ-1:0] status;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pend;

    assign hit = (bus.port_id[7:6] == BASE_ADDR[7:6]);
    assign ofs = bus.port_id[5:0];
    assign we  = bus.write_strobe & hit;

    pblaze_irq_ctrl #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .stat_w1c  (we && (ofs == OFS_STAT)),
        .mask_we   (we && (ofs == OFS_MASK)),
        .wdata     (bus.out_port[NUM_IRQ-1:0]),
        .ack       (bus.interrupt_ack),
        .status    (status),
        .mask      (mask),
        .pend      (pend),
        .interrupt (bus.interrupt),
        .state     (dbg_irq_state)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= OUT_RESET;
            end
        end else if (we && (ofs[5:4] == OFS_OUT[5:4])) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (ofs[3:0] == 4'(k)) begin
                    out_q[k] <= bus.out_port;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign out_regs[8*k +: 8] = out_q[k];
    end

    // Unmapped channels simply never match the loop bound, so they read 0.
    always_comb begin
        rdata = 8'h00;
        if (hit) begin
            if (ofs[5:4] == OFS_OUT[5:4]) begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (ofs[3:0] == 4'(k)) rdata = out_q[k];
                end
            end else if (ofs[5:4] == OFS_IN[5:4]) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    if (ofs[3:0] == 4'(k)) rdata = in_data[8*k +: 8];
                end
            end else begin
                case (ofs)
                    OFS_STAT: rdata = 8'(status);
                    OFS_MASK: rdata = 8'(mask);
                    OFS_PEND: rdata = 8'(pend);
                    OFS_ID:   rdata = ID_VAL;
                    default:  rdata = 8'h00;
                endcase
            end
        end
    end

    always_comb begin
        pop_d = '0;
        if (bus.read_strobe && hit && (ofs[5:4] == OFS_IN[5:4])) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (ofs[3:0] == 4'(k)) pop_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.in_port <= 8'h00;
            in_pop      <= '0;
        end else begin
            bus.in_port <= rdata;
            in_pop      <= pop_d;
        end
    end

endmodule

// File: tb/tb_pblaze_io_hub.sv
// Directed bench for pblaze_io_hub: port reads go through a scoreboard queue,
// register and interrupt behaviour is checked directly at the falling edge.
module tb_pblaze_io_hub;
    import pblaze_io_pkg::*;

    localparam int         NUM_OUT = 4;
    localparam int         NUM_IN  = 4;
    localparam int         NUM_IRQ = 4;
    localparam logic [7:0] BASE    = 8'h40;
    localparam int         W       = 8 + NUM_IN;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pblaze_io_hub_if bus ();
    logic [8*NUM_OUT-1:0] out_regs;
    logic [8*NUM_IN-1:0]  in_data;
    logic [NUM_IN-1:0]    in_pop;
    logic [NUM_IRQ-1:0]   irq_src;
    irq_state_e           dbg_state;

    pblaze_io_hub #(
        .NUM_OUT   (NUM_OUT),
        .NUM_IN    (NUM_IN),
        .NUM_IRQ   (NUM_IRQ),
        .BASE_ADDR (BASE),
        .OUT_RESET (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .out_regs      (out_regs),
        .in_data       (in_data),
        .in_pop        (in_pop),
        .irq_src       (irq_src),
        .dbg_irq_state (dbg_state)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic         rd_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: read data and pop strobes appear one cycle after read_strobe.
    always @(posedge clk) rd_seen <= bus.read_strobe;

    always @(negedge clk) begin
        if (rd_seen) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got %h expected none", {in_pop, bus.in_port});
            end else begin
                exp_v = exp_q.pop_front();
                if ({in_pop, bus.in_port} !== exp_v) begin
                    n_err++;
                    $display("FAIL rd_port_%h: got pop/data %h expected %h",
                             bus.port_id, {in_pop, bus.in_port}, exp_v);
                end
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.port_id      = a;
        bus.out_port     = d;
        bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] d, input logic [NUM_IN-1:0] p);
        @(negedge clk);
        bus.port_id     = a;
        bus.read_strobe = 1'b1;
        exp_q.push_back({p, d});
        @(negedge clk);
        bus.read_strobe = 1'b0;
    endtask

    task automatic wait_irq(input logic lvl, input string name);
        int i;
        i = 0;
        while (bus.interrupt !== lvl && i < 30) begin
            @(negedge clk);
            i++;
        end
        chk(name, 32'(bus.interrupt), 32'(lvl));
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        bus.interrupt_ack = 1'b1;
        @(negedge clk);
        bus.interrupt_ack = 1'b0;
    endtask

    initial begin
        bus.port_id       = 8'h00;
        bus.out_port      = 8'h00;
        bus.write_strobe  = 1'b0;
        bus.read_strobe   = 1'b0;
        bus.interrupt_ack = 1'b0;
        in_data           = 32'h4433_3C11;
        irq_src           = '0;

        // Clock/reset
        #1 reset = 1'b0;
        #1;
        chk("rst_irq", 32'(bus.interrupt), 32'h0);
        chk("rst_out", out_regs, 32'h0);
        chk("rst_inport", 32'(bus.in_port), 32'h0);
        chk("rst_pop", 32'(in_pop), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(IRQ_IDLE));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        rd(BASE + 8'h00, 8'h00, 4'b0000);
        rd(BASE + 8'h23, 8'h41, 4'b0000);

        // Output registers, unmapped channel and an address outside the window
        wr(BASE + 8'h02, 8'hA5);
        chk("out_ch2", out_regs, 32'h00A5_0000);
        rd(BASE + 8'h02, 8'hA5, 4'b0000);
        wr(BASE + 8'h07, 8'hFF);
        chk("out_unmapped", out_regs, 32'h00A5_0000);
        rd(BASE + 8'h07, 8'h00, 4'b0000);
        wr(8'h01, 8'h77);
        chk("out_miss", out_regs, 32'h00A5_0000);
        wr(BASE + 8'h00, 8'h11);
        wr(BASE + 8'h03, 8'h80);
        chk("out_all", out_regs, 32'h80A5_0011);

        // Input channels and pop strobes
        rd(BASE + 8'h11, 8'h3C, 4'b0010);
        @(negedge clk);
        chk("pop_once", 32'(in_pop), 32'h0);
        rd(BASE + 8'h13, 8'h44, 4'b1000);
        rd(BASE + 8'h14, 8'h00, 4'b0000);
        rd(8'h11, 8'h00, 4'b0000);
        rd(BASE + 8'h21, 8'h00, 4'b0000);
        rd(BASE + 8'h30, 8'h00, 4'b0000);

        // Mask register width and basic request/ack
        wr(BASE + 8'h21, 8'hFF);
        rd(BASE + 8'h21, 8'h0F, 4'b0000);
        wr(BASE + 8'h21, 8'h05);
        rd(BASE + 8'h21, 8'h05, 4'b0000);
        @(negedge clk);
        irq_src = 4'b0100;
        @(negedge clk);
        irq_src = 4'b0000;
        wait_irq(1'b1, "irq2_req");
        rd(BASE + 8'h20, 8'h04, 4'b0000);
        rd(BASE + 8'h22, 8'h04, 4'b0000);
        wr(BASE + 8'h21, 8'h00);
        chk("irq_mask_in_req", 32'(bus.interrupt), 32'h1);
        chk("state_req", 32'(dbg_state), 32'(IRQ_REQ));
        wr(BASE + 8'h21, 8'h05);
        repeat (10) @(negedge clk);
        chk("irq_hold", 32'(bus.interrupt), 32'h1);
        ack_pulse();
        chk("irq_ack_low", 32'(bus.interrupt), 32'h0);
        chk("state_holdoff", 32'(dbg_state), 32'(IRQ_HOLDOFF));
        bus.port_id      = BASE + 8'h20;
        bus.out_port     = 8'h04;
        bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
        chk("irq_gap", 32'(bus.interrupt), 32'h0);
        chk("state_idle", 32'(dbg_state), 32'(IRQ_IDLE));
        repeat (5) @(negedge clk);
        chk("irq_no_rereq", 32'(bus.interrupt), 32'h0);
        rd(BASE + 8'h22, 8'h00, 4'b0000);
        rd(BASE + 8'h20, 8'h00, 4'b0000);
        ack_pulse();
        chk("ack_in_idle", 32'(dbg_state), 32'(IRQ_IDLE));

        // Rise coinciding with a W1C of the same bit
        @(negedge clk);
        irq_src = 4'b0001;
        @(negedge clk);
        irq_src = 4'b0000;
        wait_irq(1'b1, "irq0_req");
        ack_pulse();
        chk("irq0_ack_low", 32'(bus.interrupt), 32'h0);
        bus.port_id      = BASE + 8'h20;
        bus.out_port     = 8'h01;
        bus.write_strobe = 1'b1;
        irq_src          = 4'b0001;
        @(negedge clk);
        bus.write_strobe = 1'b0;
        irq_src          = 4'b0000;
        chk("irq0_gap", 32'(bus.interrupt), 32'h0);
        @(negedge clk);
        chk("irq0_rereq", 32'(bus.interrupt), 32'h1);
        rd(BASE + 8'h20, 8'h01, 4'b0000);

        // Asynchronous reset while requesting with live output registers
        @(negedge clk);
        chk("pre_rst_irq", 32'(bus.interrupt), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("arst_irq", 32'(bus.interrupt), 32'h0);
        chk("arst_out", out_regs, 32'h0);
        chk("arst_state", 32'(dbg_state), 32'(IRQ_IDLE));
        chk("arst_inport", 32'(bus.in_port), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_pop", 32'(in_pop), 32'h0);
        rd(BASE + 8'h20, 8'h00, 4'b0000);
        rd(BASE + 8'h21, 8'h00, 4'b0000);
        rd(BASE + 8'h23, 8'h41, 4'b0000);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
